display_scan_ctrl: RTL and testbench

Sequential scan controller for the 4-digit multiplexed 7-segment display of the coffee machine.
- Generates the 2-bit digit counter that drives the per-state segment interface blocks (S0..S3, SR, SP, SN, VL).
- Samples the segment pattern those blocks return.
- Drives active-low anodes and segments with anti-ghosting blanking.
- Restarts the scan on machine-state change and flags illegal state encodings.

---
 rtl/display_pkg.sv | 43 ++++
 rtl/scan_prescaler.sv | 49 ++++
 rtl/display_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the coffee-machine display scan: state bit positions,
// anode/segment patterns and the scan FSM state type.
package display_pkg;

    localparam int S0_BIT = 0;
    localparam int S1_BIT = 1;
    localparam int S2_BIT = 2;
    localparam int S3_BIT = 3;
    localparam int SR_BIT = 4;
    localparam int SP_BIT = 5;
    localparam int SN_BIT = 6;
    localparam int VL_BIT = 7;

    localparam logic [3:0] ANODE_D0  = 4'b0111;
    localparam logic [3:0] ANODE_D1  = 4'b1011;
    localparam logic [3:0] ANODE_D2  = 4'b1101;
    localparam logic [3:0] ANODE_D3  = 4'b1110;
    localparam logic [3:0] ANODE_OFF = 4'hF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_t;

    // Digit 0 is the leftmost position, which sits on anode bit 3.
    function automatic logic [3:0] anode_for(input logic [1:0] digit);
        logic [3:0] pattern;
        case (digit)
            2'd0:    pattern = ANODE_D0;
            2'd1:    pattern = ANODE_D1;
            2'd2:    pattern = ANODE_D2;
            default: pattern = ANODE_D3;
        endcase
        return pattern;
    endfunction

    function automatic logic is_one_hot(input logic [VL_BIT:S0_BIT] bus);
        return (bus != '0) && ((bus & (bus - 8'd1)) == '0);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler: counts 0..SCAN_DIV-1 and reports slot end, the sample
// cycle and whether the next count falls inside the blanking window.
module scan_prescaler #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 8,
    parameter int DIV_WIDTH    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_restart,
    output logic       o_slotEnd,
    output logic       o_sampleNow,
`ifdef DISPLAY_DIM_EN
    output logic [1:0] o_nextTop,
`endif
    output logic       o_nextBlank
);

    localparam logic [DIV_WIDTH-1:0] LAST_COUNT   = DIV_WIDTH'(SCAN_DIV - 1);
    localparam logic [DIV_WIDTH-1:0] BLANK_END    = DIV_WIDTH'(BLANK_CYCLES);
    localparam logic [DIV_WIDTH-1:0] SAMPLE_COUNT = DIV_WIDTH'(BLANK_CYCLES - 1);

    logic [DIV_WIDTH-1:0] r_count;
    logic [DIV_WIDTH-1:0] w_next;

    // Restart wins over the natural wrap so a new message always starts a fresh slot.
    always_comb begin
        w_next = r_count + 1'b1;
        if (i_restart || (r_count == LAST_COUNT)) begin
            w_next = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_slotEnd   = (r_count == LAST_COUNT);
    assign o_sampleNow = (r_count == SAMPLE_COUNT);
    assign o_nextBlank = (w_next < BLANK_END);
`ifdef DISPLAY_DIM_EN
    assign o_nextTop   = w_next[DIV_WIDTH-1 -: 2];
`endif

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller with anti-ghosting blanking.
// Optional brightness control via the DISPLAY_DIM_EN macro (adds the dim port).
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 8,
    parameter int DIV_WIDTH    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [VL_BIT:0]   state_bus,
    input  logic [6:0]        seg_in,
`ifdef DISPLAY_DIM_EN
    input  logic [1:0]        dim,
`endif
    output logic [1:0]        contador,
    output logic [3:0]        digit_n,
    output logic [6:0]        seg_n,
    output logic              state_err
);

    scan_state_t      r_state;
    scan_state_t      w_stateNext;
    logic [VL_BIT:0]  r_stateCopy;
    logic [1:0]       r_contador;
    logic [1:0]       w_contadorNext;
    logic [6:0]       r_segReg;
    logic [6:0]       w_segRegNext;
    logic [3:0]       r_digitN;
    logic [3:0]       w_digitNext;
    logic [6:0]       r_segN;
    logic [6:0]       w_segNext;
    logic             r_stateErr;

    logic             w_valid;
    logic             w_restart;
    logic             w_slotEnd;
    logic             w_sampleNow;
    logic             w_nextBlank;
`ifdef DISPLAY_DIM_EN
    logic [1:0]       w_nextTop;
`endif

    // An invalid bus, a new valid state or leaving IDLE all restart the slot at the leftmost digit.
    assign w_valid   = is_one_hot(state_bus);
    assign w_restart = !w_valid || (state_bus != r_stateCopy) || (r_state == IDLE);

    scan_prescaler #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .DIV_WIDTH    (DIV_WIDTH)
    ) u_prescaler (
        .clock       (clock),
        .reset       (reset),
        .i_restart   (w_restart),
        .o_slotEnd   (w_slotEnd),
        .o_sampleNow (w_sampleNow),
`ifdef DISPLAY_DIM_EN
        .o_nextTop   (w_nextTop),
`endif
        .o_nextBlank (w_nextBlank)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_stateCopy <= '0;
            r_contador  <= 2'b00;
            r_segReg    <= '0;
            r_digitN    <= ANODE_OFF;
            r_segN      <= SEG_BLANK;
            r_stateErr  <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_stateCopy <= state_bus;
            r_contador  <= w_contadorNext;
            r_segReg    <= w_segRegNext;
            r_digitN    <= w_digitNext;
            r_segN      <= w_segNext;
            r_stateErr  <= r_stateErr | ~w_valid;
        end
    end

    // Outputs are computed from next-cycle values so the registered pins line up with the FSM state.
    always_comb begin
        w_stateNext    = r_state;
        w_contadorNext = r_contador;
        w_segRegNext   = r_segReg;
        w_digitNext    = ANODE_OFF;
        w_segNext      = SEG_BLANK;

        if (!w_valid) begin
            w_stateNext    = IDLE;
            w_contadorNext = 2'b00;
        end else if (w_restart) begin
            w_stateNext    = BLANK;
            w_contadorNext = 2'b00;
        end else begin
            if (w_slotEnd) begin
                w_contadorNext = r_contador + 2'd1;
            end
            if (w_sampleNow) begin
                w_segRegNext = seg_in;
            end
            w_stateNext = w_nextBlank ? BLANK : SHOW;
        end

        if (w_stateNext == SHOW) begin
`ifdef DISPLAY_DIM_EN
            w_digitNext = (w_nextTop <= dim) ? anode_for(w_contadorNext) : ANODE_OFF;
`else
            w_digitNext = anode_for(w_contadorNext);
`endif
            w_segNext   = ~w_segRegNext;
        end
    end

    assign contador  = r_contador;
    assign digit_n   = r_digitN;
    assign seg_n     = r_segN;
    assign state_err = r_stateErr;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with SCAN_DIV=10, BLANK_CYCLES=2.
module tb_display_scan_ctrl;

    logic       clock;
    logic       reset;
    logic [7:0] state_bus;
    logic [6:0] seg_in;
    logic [1:0] contador;
    logic [3:0] digit_n;
    logic [6:0] seg_n;
    logic       state_err;

    int checks;
    int errors;
    int cyc;

    typedef struct {
        int         n;
        logic [1:0] cont;
        logic [3:0] dig;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs[16];

    display_scan_ctrl #(
        .SCAN_DIV     (10),
        .BLANK_CYCLES (2),
        .DIV_WIDTH    (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .state_bus (state_bus),
        .seg_in    (seg_in),
`ifdef DISPLAY_DIM_EN
        .dim       (2'd3),
`endif
        .contador  (contador),
        .digit_n   (digit_n),
        .seg_n     (seg_n),
        .state_err (state_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for the per-state interface blocks: pattern depends only on contador.
    always_comb begin
        case (contador)
            2'd0:    seg_in = 7'h39;
            2'd1:    seg_in = 7'h79;
            2'd2:    seg_in = 7'h3F;
            default: seg_in = 7'h00;
        endcase
    end

    task automatic applyStimulus(input logic rst, input logic [7:0] bus);
        reset     = rst;
        state_bus = bus;
    endtask

    task automatic stepCycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clock);
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkDisplay(input string label, input logic [1:0] cont, input logic [3:0] dig,
                                input logic [6:0] seg, input logic err);
        checkOutput({label, " contador"},  {6'd0, contador},  {6'd0, cont});
        checkOutput({label, " digit_n"},   {4'd0, digit_n},   {4'd0, dig});
        checkOutput({label, " seg_n"},     {1'b0, seg_n},     {1'b0, seg});
        checkOutput({label, " state_err"}, {7'd0, state_err}, {7'd0, err});
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // n = cycles since the restart edge; prescaler = n%10, contador = (n/10)%4
        vecs[0]  = '{0,  2'd0, 4'b1111, 7'h7F};
        vecs[1]  = '{1,  2'd0, 4'b1111, 7'h7F};
        vecs[2]  = '{2,  2'd0, 4'b0111, 7'h46};
        vecs[3]  = '{9,  2'd0, 4'b0111, 7'h46};
        vecs[4]  = '{10, 2'd1, 4'b1111, 7'h7F};
        vecs[5]  = '{11, 2'd1, 4'b1111, 7'h7F};
        vecs[6]  = '{12, 2'd1, 4'b1011, 7'h06};
        vecs[7]  = '{19, 2'd1, 4'b1011, 7'h06};
        vecs[8]  = '{20, 2'd2, 4'b1111, 7'h7F};
        vecs[9]  = '{22, 2'd2, 4'b1101, 7'h40};
        vecs[10] = '{29, 2'd2, 4'b1101, 7'h40};
        vecs[11] = '{30, 2'd3, 4'b1111, 7'h7F};
        vecs[12] = '{32, 2'd3, 4'b1110, 7'h7F};
        vecs[13] = '{39, 2'd3, 4'b1110, 7'h7F};
        vecs[14] = '{40, 2'd0, 4'b1111, 7'h7F};
        vecs[15] = '{42, 2'd0, 4'b0111, 7'h46};

        $display("[TB] reset values");
        applyStimulus(1'b1, 8'h08);
        #3;
        checkDisplay("reset", 2'd0, 4'b1111, 7'h7F, 1'b0);
        @(negedge clock);
        applyStimulus(1'b0, 8'h08);
        @(negedge clock);
        cyc = 0;

        $display("[TB] scan sequence for S3");
        for (int i = 0; i < 16; i++) begin
            while (cyc < vecs[i].n) begin
                @(negedge clock);
                cyc++;
            end
            checkDisplay($sformatf("scan n=%0d", vecs[i].n), vecs[i].cont, vecs[i].dig, vecs[i].seg, 1'b0);
        end

        $display("[TB] state change mid-slot");
        stepCycles(65 - cyc);
        checkDisplay("pre-change", 2'd2, 4'b1101, 7'h40, 1'b0);
        applyStimulus(1'b0, 8'h01);
        stepCycles(1);
        checkDisplay("change +1", 2'd0, 4'b1111, 7'h7F, 1'b0);
        stepCycles(1);
        checkDisplay("change +2", 2'd0, 4'b1111, 7'h7F, 1'b0);
        stepCycles(1);
        checkDisplay("change first show", 2'd0, 4'b0111, 7'h46, 1'b0);

        $display("[TB] state change on slot end");
        stepCycles(27);
        checkDisplay("pre slot end", 2'd2, 4'b1101, 7'h40, 1'b0);
        applyStimulus(1'b0, 8'h08);
        stepCycles(1);
        checkDisplay("change wins", 2'd0, 4'b1111, 7'h7F, 1'b0);
        stepCycles(2);
        checkDisplay("change wins show", 2'd0, 4'b0111, 7'h46, 1'b0);

        $display("[TB] illegal encodings");
        applyStimulus(1'b0, 8'h0C);
        stepCycles(1);
        checkDisplay("two-hot", 2'd0, 4'b1111, 7'h7F, 1'b1);
        applyStimulus(1'b0, 8'h00);
        stepCycles(1);
        checkDisplay("zero-hot", 2'd0, 4'b1111, 7'h7F, 1'b1);
        stepCycles(3);
        checkDisplay("idle held", 2'd0, 4'b1111, 7'h7F, 1'b1);
        applyStimulus(1'b0, 8'h08);
        stepCycles(1);
        checkDisplay("resume", 2'd0, 4'b1111, 7'h7F, 1'b1);
        stepCycles(2);
        checkDisplay("resume show", 2'd0, 4'b0111, 7'h46, 1'b1);
        stepCycles(12);
        checkDisplay("resume digit1", 2'd1, 4'b1011, 7'h06, 1'b1);

        $display("[TB] async reset mid-show");
        #2;
        reset = 1'b1;
        #1;
        checkDisplay("async reset", 2'd0, 4'b1111, 7'h7F, 1'b0);
        @(negedge clock);
        applyStimulus(1'b0, 8'h08);
        stepCycles(1);
        checkDisplay("post reset", 2'd0, 4'b1111, 7'h7F, 1'b0);
        stepCycles(2);
        checkDisplay("post reset show", 2'd0, 4'b0111, 7'h46, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
